// File: rtl/secded_encoder.sv
// SECDED encoder for 32-bit words: 6 Hamming check bits plus an overall
// parity bit, in the same layout the correction/detection block expects.
// Two-stage valid/ready pipeline with full backpressure, plus a one-shot
// error-injection mask that is XORed into the next word leaving stage 1.
module secded_encoder #(
  parameter int INJ_EN = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic [6:0]  out_parity,
  input  logic        inj_arm,
  input  logic [38:0] inj_mask,
  output logic        inj_pending,
  output logic [15:0] word_count
);

  localparam bit InjOn = (INJ_EN != 0);

  // Hamming group XORs. Codeword positions 1..38 with check bits at the
  // powers of two; data bits fill the other positions in ascending order.
  function automatic logic [5:0] hamming_groups(input logic [31:0] d);
    logic [5:0] g;
    int         k;
    g = '0;
    k = 0;
    for (int pos = 1; pos <= 38; pos++) begin
      if ((pos & (pos - 1)) != 0) begin
        for (int i = 0; i < 6; i++) begin
          if (pos[i]) g[i] = g[i] ^ d[k[4:0]];
        end
        k++;
      end
    end
    return g;
  endfunction

  logic        s1_vld_q, s1_vld_d;
  logic [31:0] s1_data_q;
  logic [5:0]  s1_grp_q;
  logic        s2_vld_q, s2_vld_d;
  logic [31:0] s2_data_q, s2_data_d;
  logic [6:0]  s2_par_q, s2_par_d;
  logic        inj_pend_q, inj_pend_d;
  logic [38:0] inj_mask_q, inj_mask_d;
  logic [15:0] cnt_q, cnt_d;

  logic        s2_load;
  logic        s1_load;
  logic        arm;
  logic        inj_apply;
  logic [6:0]  clean_par;

  assign s2_load   = s1_vld_q & (~s2_vld_q | out_ready);
  assign in_ready  = ~s1_vld_q | s2_load;
  assign s1_load   = in_valid & in_ready;
  assign arm       = InjOn & inj_arm;
  assign inj_apply = inj_pend_q & s2_load;
  assign clean_par = {(^s1_data_q) ^ (^s1_grp_q), s1_grp_q};

  // Next-state for valids, stage-2 data, injection state and word counter.
  always_comb begin
    s1_vld_d   = s1_vld_q;
    s2_vld_d   = s2_vld_q;
    s2_data_d  = s2_data_q;
    s2_par_d   = s2_par_q;
    inj_pend_d = inj_pend_q;
    inj_mask_d = inj_mask_q;
    cnt_d      = cnt_q + 16'(s2_vld_q & out_ready);

    if (s1_load)      s1_vld_d = 1'b1;
    else if (s2_load) s1_vld_d = 1'b0;

    if (s2_load)        s2_vld_d = 1'b1;
    else if (out_ready) s2_vld_d = 1'b0;

    // Parity is always on the clean word; the mask is applied on top.
    if (s2_load) begin
      s2_data_d = s1_data_q;
      s2_par_d  = clean_par;
      if (inj_apply) begin
        s2_data_d = s1_data_q ^ inj_mask_q[31:0];
        s2_par_d  = clean_par ^ inj_mask_q[38:32];
      end
    end

    // A fresh arm wins over the clear, so an arm coinciding with the load
    // leaves the new mask pending while the old one goes out with the word.
    if (arm) begin
      inj_mask_d = inj_mask;
      inj_pend_d = 1'b1;
    end else if (inj_apply) begin
      inj_pend_d = 1'b0;
    end
  end

  // Control and output registers, cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_vld_q   <= 1'b0;
      s2_vld_q   <= 1'b0;
      s2_data_q  <= '0;
      s2_par_q   <= '0;
      inj_pend_q <= 1'b0;
      inj_mask_q <= '0;
      cnt_q      <= '0;
    end else begin
      s1_vld_q   <= s1_vld_d;
      s2_vld_q   <= s2_vld_d;
      s2_data_q  <= s2_data_d;
      s2_par_q   <= s2_par_d;
      inj_pend_q <= inj_pend_d;
      inj_mask_q <= inj_mask_d;
      cnt_q      <= cnt_d;
    end
  end

  // Stage 1 datapath: capture the word and its group XORs on accept.
  always_ff @(posedge clk) begin
    if (s1_load) begin
      s1_data_q <= in_data;
      s1_grp_q  <= hamming_groups(in_data);
    end
  end

  assign out_valid   = s2_vld_q;
  assign out_data    = s2_data_q;
  assign out_parity  = s2_par_q;
  assign inj_pending = inj_pend_q;
  assign word_count  = cnt_q;

endmodule
